// File: rtl/nx_ia_mem_arbiter.sv
// nx_ia_mem_arbiter: arbitrates one single-port memory between the software
// indirect-access port and the datapath. The datapath has priority, but a
// software request is forced through after STARVE_LIMIT consecutive denials,
// or at once when yield is high. Read data from the memory comes back one
// cycle after the access. The datapath is told when that data is its own.
module nx_ia_mem_arbiter #(
  parameter int N_ADDR_BITS  = 5,
  parameter int N_DATA_BITS  = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // software indirect-access port
  input  logic                   sw_cs,
  input  logic                   sw_ce,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  input  logic                   yield,
  output logic                   grant,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  // datapath port
  input  logic                   hw_req,
  input  logic                   hw_we,
  input  logic [N_ADDR_BITS-1:0] hw_add,
  input  logic [N_DATA_BITS-1:0] hw_wdat,
  output logic                   hw_ack,
  output logic                   hw_rd_vld,
  output logic [N_DATA_BITS-1:0] hw_rdat,
  // shared memory
  output logic                   mem_cs,
  output logic                   mem_ce,
  output logic                   mem_we,
  output logic [N_ADDR_BITS-1:0] mem_add,
  output logic [N_DATA_BITS-1:0] mem_wdat,
  input  logic [N_DATA_BITS-1:0] mem_rdat,
  // statistics
  output logic [15:0]            stat_forced_cnt
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [15:0]         FORCED_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_HW   = 2'd1,
    SEL_SW   = 2'd2
  } sel_e;

  sel_e                sel;
  logic                force_sw;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [15:0]         forced_cnt_q, forced_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_own_hw_q, rd_own_hw_d;

  // Software jumps the queue on timer urgency or once it has starved long enough.
  assign force_sw = yield || (starve_cnt_q == STARVE_MAX);

  // Pick the requester that owns the memory this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sel = SEL_NONE;
    if (sw_cs && (!hw_req || force_sw)) begin
      sel = SEL_SW;
    end else if (hw_req) begin
      sel = SEL_HW;
    end
  end

  assign grant  = (sel == SEL_SW);
  assign hw_ack = (sel == SEL_HW);

  // Steer the winner onto the memory strobes; idle memory sees all zeros.
  always_comb begin
    mem_cs   = 1'b0;
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    mem_add  = '0;
    mem_wdat = '0;
    unique case (sel)
      SEL_SW: begin
        mem_cs   = 1'b1;
        mem_ce   = sw_ce;
        mem_we   = sw_we;
        mem_add  = sw_add;
        mem_wdat = sw_wdat;
      end
      SEL_HW: begin
        mem_cs   = 1'b1;
        mem_we   = hw_we;
        mem_add  = hw_add;
        mem_wdat = hw_wdat;
      end
      default: ;
    endcase
  end

  // Next-state for the starvation counter, forced-grant statistic and read tracking.
  always_comb begin
    starve_cnt_d = '0;
    if (sw_cs && !grant) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX
                                                  : starve_cnt_q + STARVE_W'(1);
    end

    forced_cnt_d = forced_cnt_q;
    if (grant && hw_req && (forced_cnt_q != FORCED_MAX)) begin
      forced_cnt_d = forced_cnt_q + 16'd1;
    end

    // Compares (sw_ce) have no write strobe, so they count as reads here.
    rd_pend_d   = mem_cs && !mem_we;
    rd_own_hw_d = hw_ack;
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      forced_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_own_hw_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      starve_cnt_q <= starve_cnt_d;
      forced_cnt_q <= forced_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_own_hw_q  <= rd_own_hw_d;
    end
  end

  assign hw_rd_vld       = rd_pend_q && rd_own_hw_q;
  assign hw_rdat         = mem_rdat;
  assign sw_rdat         = mem_rdat;
  assign stat_forced_cnt = forced_cnt_q;

endmodule

// File: tb/tb_nx_ia_mem_arbiter.sv
// Self-checking bench for nx_ia_mem_arbiter: a table of single-cycle
// arbitration vectors, hand-written multi-cycle sequences, a randomized run
// against a behavioural model, and saturation of the forced-grant counter.
module tb_nx_ia_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw_cs, sw_ce, sw_we, yield;
  logic [AW-1:0] sw_add;
  logic [DW-1:0] sw_wdat;
  logic          grant;
  logic [DW-1:0] sw_rdat;
  logic          hw_req, hw_we;
  logic [AW-1:0] hw_add;
  logic [DW-1:0] hw_wdat;
  logic          hw_ack, hw_rd_vld;
  logic [DW-1:0] hw_rdat;
  logic          mem_cs, mem_ce, mem_we;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] mem_rdat;
  logic [15:0]   stat_forced_cnt;

  int errors = 0;
  int checks = 0;

  nx_ia_mem_arbiter #(
    .N_ADDR_BITS (AW),
    .N_DATA_BITS (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw_cs          (sw_cs),
    .sw_ce          (sw_ce),
    .sw_we          (sw_we),
    .sw_add         (sw_add),
    .sw_wdat        (sw_wdat),
    .yield          (yield),
    .grant          (grant),
    .sw_rdat        (sw_rdat),
    .hw_req         (hw_req),
    .hw_we          (hw_we),
    .hw_add         (hw_add),
    .hw_wdat        (hw_wdat),
    .hw_ack         (hw_ack),
    .hw_rd_vld      (hw_rd_vld),
    .hw_rdat        (hw_rdat),
    .mem_cs         (mem_cs),
    .mem_ce         (mem_ce),
    .mem_we         (mem_we),
    .mem_add        (mem_add),
    .mem_wdat       (mem_wdat),
    .mem_rdat       (mem_rdat),
    .stat_forced_cnt(stat_forced_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    sw_cs = 0; sw_ce = 0; sw_we = 0; yield = 0; sw_add = '0; sw_wdat = '0;
    hw_req = 0; hw_we = 0; hw_add = '0; hw_wdat = '0; mem_rdat = '0;
  endtask

  // Synchronous-looking reset pulse; leaves us 1 time unit after a posedge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: who wins, from the arbitration rules in plain terms.
  // ---------------------------------------------------------------------------
  int m_denied;      // consecutive cycles software asked and was refused
  int m_forced;      // forced software grants seen so far
  bit m_hw_read_ret; // a datapath read was accepted last cycle

  function automatic bit model_sw_wins();
    bit urgent;
    urgent = yield || (m_denied >= SL);
    return sw_cs && (!hw_req || urgent);
  endfunction

  task automatic model_reset();
    m_denied = 0; m_forced = 0; m_hw_read_ret = 0;
  endtask

  // Check every output against the model for the current inputs, then clock.
  task automatic model_cycle(input string tag);
    bit sw_w, hw_w;
    @(negedge clk);
    sw_w = model_sw_wins();
    hw_w = hw_req && !sw_w;
    check({tag, " grant"}, grant, sw_w);
    check({tag, " hw_ack"}, hw_ack, hw_w);
    check({tag, " mem_cs"}, mem_cs, sw_w || hw_w);
    check({tag, " mem_ce"}, mem_ce, sw_w ? sw_ce : 1'b0);
    check({tag, " mem_we"}, mem_we, sw_w ? sw_we : (hw_w ? hw_we : 1'b0));
    check({tag, " mem_add"}, mem_add, sw_w ? sw_add : (hw_w ? hw_add : '0));
    check({tag, " mem_wdat"}, mem_wdat, sw_w ? sw_wdat : (hw_w ? hw_wdat : '0));
    check({tag, " hw_rd_vld"}, hw_rd_vld, m_hw_read_ret);
    check({tag, " hw_rdat"}, hw_rdat, mem_rdat);
    check({tag, " sw_rdat"}, sw_rdat, mem_rdat);
    check({tag, " forced"}, stat_forced_cnt, 16'(m_forced));
    @(posedge clk);
    if (sw_cs && !sw_w) m_denied = (m_denied < SL) ? m_denied + 1 : SL;
    else                m_denied = 0;
    if (sw_w && hw_req && m_forced < 65535) m_forced++;
    m_hw_read_ret = hw_w && !hw_we;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Single-cycle arbitration table (starting from a freshly reset block).
  // ---------------------------------------------------------------------------
  typedef struct {
    bit sw_cs, sw_ce, sw_we, yield, hw_req, hw_we;
    bit e_grant, e_ack, e_cs, e_ce, e_we;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //          cs ce we yl hr hw   gr ak cs ce we
    vecs[0] = '{1, 0, 1, 0, 0, 0,   1, 0, 1, 0, 1}; // sw write only
    vecs[1] = '{1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0}; // sw read
    vecs[2] = '{1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0}; // sw compare
    vecs[3] = '{0, 0, 0, 0, 1, 0,   0, 1, 1, 0, 0}; // hw read
    vecs[4] = '{0, 0, 0, 0, 1, 1,   0, 1, 1, 0, 1}; // hw write
    vecs[5] = '{1, 1, 1, 0, 1, 0,   0, 1, 1, 0, 0}; // contention, hw wins
    vecs[6] = '{1, 0, 1, 1, 1, 0,   1, 0, 1, 0, 1}; // contention + yield, sw wins
    vecs[7] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0}; // idle
    vecs[8] = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0}; // yield without request
    vecs[9] = '{1, 1, 0, 1, 0, 0,   1, 0, 1, 1, 0}; // sw compare with yield

    rst_n = 1'b0;
    idle_inputs();
    #12;
    // Reset state, sampled while reset is still held.
    check("reset hw_rd_vld", hw_rd_vld, 1'b0);
    check("reset forced", stat_forced_cnt, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- table ----
    sw_add = 5'd5; sw_wdat = 64'hA5; hw_add = 5'd3; hw_wdat = 64'h77;
    for (int i = 0; i < 10; i++) begin
      sw_cs = vecs[i].sw_cs; sw_ce = vecs[i].sw_ce; sw_we = vecs[i].sw_we;
      yield = vecs[i].yield; hw_req = vecs[i].hw_req; hw_we = vecs[i].hw_we;
      @(negedge clk);
      check($sformatf("vec%0d grant", i), grant, vecs[i].e_grant);
      check($sformatf("vec%0d hw_ack", i), hw_ack, vecs[i].e_ack);
      check($sformatf("vec%0d mem_cs", i), mem_cs, vecs[i].e_cs);
      check($sformatf("vec%0d mem_ce", i), mem_ce, vecs[i].e_ce);
      check($sformatf("vec%0d mem_we", i), mem_we, vecs[i].e_we);
      check($sformatf("vec%0d mem_add", i), mem_add,
            vecs[i].e_grant ? 64'd5 : (vecs[i].e_ack ? 64'd3 : 64'd0));
      check($sformatf("vec%0d mem_wdat", i), mem_wdat,
            vecs[i].e_grant ? 64'hA5 : (vecs[i].e_ack ? 64'h77 : 64'd0));
      next_cycle();
    end
    // Exactly one forced grant happened in the table (row 6).
    check("table forced", stat_forced_cnt, 16'd1);

    // ---- starvation: 8 datapath acks, then software is forced through ----
    do_reset();
    hw_req = 1; hw_we = 0; hw_add = 5'd3; sw_cs = 1; sw_add = 5'd9;
    for (int c = 0; c < SL; c++) begin
      @(negedge clk);
      check($sformatf("starve c%0d hw_ack", c), hw_ack, 1'b1);
      check($sformatf("starve c%0d grant", c), grant, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    check("starve forced grant", grant, 1'b1);
    check("starve forced hw_ack", hw_ack, 1'b0);
    check("starve forced mem_add", mem_add, 64'd9);
    next_cycle();
    check("starve stat", stat_forced_cnt, 16'd1);
    @(negedge clk);
    check("starve after hw_ack", hw_ack, 1'b1);
    next_cycle();

    // ---- yield with contention: sw now, hw the next cycle ----
    do_reset();
    hw_req = 1; hw_we = 0; hw_add = 5'd4; sw_cs = 1; yield = 1;
    @(negedge clk);
    check("yield grant", grant, 1'b1);
    check("yield hw_ack", hw_ack, 1'b0);
    next_cycle();
    sw_cs = 0; yield = 0;
    @(negedge clk);
    check("yield retry hw_ack", hw_ack, 1'b1);
    check("yield retry mem_add", mem_add, 64'd4);
    next_cycle();

    // ---- read return: hw read flags valid, sw read and compare do not ----
    do_reset();
    hw_req = 1; hw_we = 0; hw_add = 5'd7;
    next_cycle();
    hw_req = 0; mem_rdat = 64'h1234;
    @(negedge clk);
    check("hwrd vld", hw_rd_vld, 1'b1);
    check("hwrd rdat", hw_rdat, 64'h1234);
    next_cycle();
    check("hwrd vld one-shot", hw_rd_vld, 1'b0);
    sw_cs = 1; sw_we = 0; sw_add = 5'd7;
    next_cycle();
    sw_cs = 0; mem_rdat = 64'hBEEF;
    @(negedge clk);
    check("swrd no vld", hw_rd_vld, 1'b0);
    check("swrd rdat", sw_rdat, 64'hBEEF);
    next_cycle();
    sw_cs = 1; sw_ce = 1;
    next_cycle();
    sw_cs = 0; sw_ce = 0;
    @(negedge clk);
    check("cmp no vld", hw_rd_vld, 1'b0);
    next_cycle();

    // ---- reset mid-read discards the return and clears the counters ----
    do_reset();
    hw_req = 1; sw_cs = 1; yield = 1;
    next_cycle();                      // one forced grant
    yield = 0;
    repeat (3) next_cycle();           // three sw denials
    sw_cs = 0; hw_we = 0; hw_add = 5'd2;
    next_cycle();                      // hw read acked at this edge
    check("prereset forced", stat_forced_cnt, 16'd1);
    rst_n = 1'b0;
    hw_req = 0;
    #1;
    check("midrd reset vld", hw_rd_vld, 1'b0);
    check("midrd reset forced", stat_forced_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrd post vld", hw_rd_vld, 1'b0);
    // Starvation counter restarted from zero: still 8 full hw cycles before force.
    hw_req = 1; sw_cs = 1;
    for (int c = 0; c < SL; c++) begin
      @(negedge clk);
      check($sformatf("postrst c%0d hw_ack", c), hw_ack, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    check("postrst forced grant", grant, 1'b1);
    next_cycle();

    // ---- randomized run against the model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      // The datapath holds its request steady until accepted.
      if (!hw_req || hw_ack === 1'b1) begin
        hw_req  = ($urandom_range(0, 3) != 0);
        hw_we   = $urandom_range(0, 1);
        hw_add  = AW'($urandom);
        hw_wdat = {$urandom, $urandom};
      end
      sw_cs    = ($urandom_range(0, 2) != 0);
      sw_ce    = ($urandom_range(0, 3) == 0);
      sw_we    = sw_ce ? 1'b0 : 1'($urandom_range(0, 1));
      sw_add   = AW'($urandom);
      sw_wdat  = {$urandom, $urandom};
      yield    = ($urandom_range(0, 15) == 0);
      mem_rdat = {$urandom, $urandom};
      model_cycle($sformatf("rnd%0d", c));
    end

    // ---- forced-grant counter saturation ----
    do_reset();
    sw_cs = 1; hw_req = 1; yield = 1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat 0xFFFE", stat_forced_cnt, 16'hFFFE);
    next_cycle();
    check("sat 0xFFFF", stat_forced_cnt, 16'hFFFF);
    repeat (4) next_cycle();
    check("sat hold", stat_forced_cnt, 16'hFFFF);
    idle_inputs();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nx_ia_mem_arbiter.md
NX_IA_MEM_ARBITER -- requirements
Module: nx_ia_mem_arbiter

Interface
REQ-001 SHALL have parameter N_ADDR_BITS, default 5, address width of the shared memory.
REQ-002 SHALL have parameter N_DATA_BITS, default 64, data width of the shared memory.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, number of consecutive denied software cycles after which software is forced through.
REQ-004 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- sw_cs / sw_ce / sw_we  in  1 each  software (indirect-access) request, compare, write.
- sw_add  in  N_ADDR_BITS  software address.
- sw_wdat  in  N_DATA_BITS  software write data.
- yield  in  1  software timer-expiry urgency.
- grant  out  1  software access accepted this cycle.
- sw_rdat  out  N_DATA_BITS  read data to software.
- hw_req / hw_we  in  1 each  datapath request and write.
- hw_add  in  N_ADDR_BITS  datapath address.
- hw_wdat  in  N_DATA_BITS  datapath write data.
- hw_ack  out  1  datapath access accepted this cycle.
- hw_rd_vld  out  1  datapath read data valid.
- hw_rdat  out  N_DATA_BITS  datapath read data.
- mem_cs / mem_ce / mem_we  out  1 each  memory strobes.
- mem_add  out  N_ADDR_BITS  memory address.
- mem_wdat  out  N_DATA_BITS  memory write data.
- mem_rdat  in  N_DATA_BITS  memory read data, one-cycle latency.
- stat_forced_cnt  out  16  count of forced software grants, saturating.

Function
REQ-005 SHALL compute force_sw = yield OR (starve_cnt_r == STARVE_LIMIT).
REQ-006 SHALL select software when sw_cs AND (NOT hw_req OR force_sw); otherwise SHALL select the datapath when hw_req is high.
REQ-007 SHALL drive grant = sw_cs AND sw selected, and hw_ack = hw_req AND NOT sw selected; both are combinational, in the same cycle as the request, and never high together.
REQ-008 SHALL drive mem_cs, mem_we, mem_add and mem_wdat combinationally from the selected requester; mem_ce SHALL equal sw_ce when software is granted and 0 otherwise; with no request, all mem strobes SHALL be 0.
REQ-009 SHALL keep starve_cnt_r (width clog2(STARVE_LIMIT+1)): increment when sw_cs AND NOT grant, saturating at STARVE_LIMIT; clear to 0 when grant is high or sw_cs is low.
REQ-010 SHALL increment stat_forced_cnt by 1 on every cycle where grant is high AND hw_req is high, saturating at 0xFFFF.
REQ-011 SHALL register rd_pend_r = mem_cs AND NOT mem_we, and rd_own_hw_r = hw_ack.
REQ-012 SHALL drive hw_rd_vld = rd_pend_r AND rd_own_hw_r, i.e. exactly one cycle after a datapath read ack.
REQ-013 SHALL pass hw_rdat = mem_rdat and sw_rdat = mem_rdat; software samples sw_rdat the cycle after grant.
REQ-014 Compare accesses (sw_ce) SHALL be treated as reads for rd_pend_r, and SHALL NOT assert hw_rd_vld.
REQ-015 Simultaneous yield and hw_req: software SHALL win; the datapath SHALL retry and its hw_req SHALL be held with stable fields until hw_ack.
REQ-016 Back-to-back datapath reads SHALL be acked every cycle while software is idle, giving full throughput.

Reset
REQ-017 On rst_n low (asynchronous), the block SHALL clear starve_cnt_r, rd_pend_r, rd_own_hw_r and stat_forced_cnt to 0; hw_rd_vld SHALL be 0.
REQ-018 Reset mid-read SHALL discard the pending return: no hw_rd_vld SHALL follow reset deassertion.

Structure
REQ-019 No shared package SHALL be needed; parameters SHALL be local, and the requester-select encoding (SEL_NONE/SEL_HW/SEL_SW) SHALL be a local enum.
REQ-020 The block SHALL be a single module with no sub-modules.

Verification
REQ-021 sw_cs write only, addr 5, data 0xA5 -> grant=1, mem_we=1, mem_add=5, mem_wdat=0xA5 in the same cycle.
REQ-022 hw_req read addr 3 continuous, sw_cs held, yield=0 -> 8 hw_acks, then grant=1 on the 9th cycle, stat_forced_cnt=1.
REQ-023 hw_req and sw_cs with yield=1 -> grant=1, hw_ack=0 that cycle; hw_ack the next cycle.
REQ-024 hw read addr 7 with mem returning 0x1234 -> hw_rd_vld=1, hw_rdat=0x1234 one cycle later; a software read yields no hw_rd_vld.
REQ-025 rst_n asserted the cycle after a hw read ack -> hw_rd_vld stays 0 and all counters read 0.
REQ-026 Force 0x10000 forced grants -> stat_forced_cnt holds at 0xFFFF.
